traffic_light_fsm: RTL and testbench

- Four-way intersection controller that consumes the 1 Hz Slow_Clock from the clock divider and sequences the NS and EW vehicle lights and a pedestrian Walk phase.
- Runs entirely in the 100 MHz Clk domain. Slow_Clock is used only as a tick-enable via rising-edge detect, never as a clock.
- Drives the board LEDs and a 4-bit seconds-remaining value for the display stage.

---
 rtl/traffic_light_fsm.sv | 162 ++++++++++++++++
 tb/tb_traffic_light_fsm.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_fsm.sv
// Four-way intersection sequencer: NS/EW vehicle lights plus a
// pedestrian walk phase, stepped by ticks derived from Slow_Clock.
module traffic_light_fsm #(
  parameter logic [3:0] GREEN_T  = 4'd8,
  parameter logic [3:0] YELLOW_T = 4'd3,
  parameter logic [3:0] ALLRED_T = 4'd1,
  parameter logic [3:0] WALK_T   = 4'd5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Slow_Clock,
  input  logic       Ped_Req,
  output logic [2:0] NS_Light,
  output logic [2:0] EW_Light,
  output logic       Walk,
  output logic [3:0] Time_Left
);

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALL_RED_1,
    EW_GREEN,
    EW_YELLOW,
    ALL_RED_2,
    WALK
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_t     state;
  state_t     state_n;
  logic [3:0] timer;
  logic [3:0] timer_n;
  logic       next_dir;
  logic       dir_n;
  logic       ped_pending;
  logic       pend_n;
  logic       sc_q;
  logic       ped_s1;
  logic       ped_s2;
  logic       ped_s3;
  logic       tick;
  logic       ped_edge;
  logic       in_green;

  assign tick      = Slow_Clock & ~sc_q;
  assign ped_edge  = ped_s2 & ~ped_s3;
  assign in_green  = (state == NS_GREEN) || (state == EW_GREEN);
  assign Time_Left = timer;

  // Lamp pattern {ns, ew, walk} shown while in a given state.
  function automatic logic [6:0] lamps(input state_t s);
    logic [6:0] l;
    l = {RED, RED, 1'b0};
    case (s)
      NS_GREEN:  l = {GRN, RED, 1'b0};
      NS_YELLOW: l = {YEL, RED, 1'b0};
      EW_GREEN:  l = {RED, GRN, 1'b0};
      EW_YELLOW: l = {RED, YEL, 1'b0};
      WALK:      l = {RED, RED, 1'b1};
      default:   l = {RED, RED, 1'b0};
    endcase
    return l;
  endfunction

  // Next state, timer reload, walk-return direction and request latch.
  always_comb begin
    state_n = state;
    timer_n = timer;
    dir_n   = next_dir;
    if (tick) begin
      if (timer <= 4'd1) begin
        case (state)
          NS_GREEN: begin
            state_n = NS_YELLOW;
            timer_n = YELLOW_T;
          end
          NS_YELLOW: begin
            state_n = ALL_RED_1;
            timer_n = ALLRED_T;
          end
          ALL_RED_1: begin
            dir_n   = 1'b1;
            state_n = ped_pending ? WALK : EW_GREEN;
            timer_n = ped_pending ? WALK_T : GREEN_T;
          end
          EW_GREEN: begin
            state_n = EW_YELLOW;
            timer_n = YELLOW_T;
          end
          EW_YELLOW: begin
            state_n = ALL_RED_2;
            timer_n = ALLRED_T;
          end
          ALL_RED_2: begin
            dir_n   = 1'b0;
            state_n = ped_pending ? WALK : NS_GREEN;
            timer_n = ped_pending ? WALK_T : GREEN_T;
          end
          WALK: begin
            state_n = next_dir ? EW_GREEN : NS_GREEN;
            timer_n = GREEN_T;
          end
          default: begin
            state_n = ALL_RED_2;
            timer_n = ALLRED_T;
          end
        endcase
      end else begin
        timer_n = timer - 4'd1;
      end
    end
    if (in_green && ped_pending && (timer > 4'd2)) begin
      timer_n = 4'd2;
    end
    pend_n = ped_pending;
    if ((state_n == WALK) && (state != WALK)) begin
      pend_n = 1'b0;
    end
    if (ped_edge && (state != WALK)) begin
      pend_n = 1'b1;
    end
  end

  // Tick edge detect and pushbutton synchroniser.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sc_q   <= 1'b0;
      ped_s1 <= 1'b0;
      ped_s2 <= 1'b0;
      ped_s3 <= 1'b0;
    end else begin
      sc_q   <= Slow_Clock;
      ped_s1 <= Ped_Req;
      ped_s2 <= ped_s1;
      ped_s3 <= ped_s2;
    end
  end

  // State, timer and registered lamp outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= ALL_RED_2;
      timer       <= ALLRED_T;
      next_dir    <= 1'b0;
      ped_pending <= 1'b0;
      NS_Light    <= RED;
      EW_Light    <= RED;
      Walk        <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      next_dir    <= dir_n;
      ped_pending <= pend_n;
      {NS_Light, EW_Light, Walk} <= lamps(state_n);
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm: expected lamp/timer
// vectors are queued per stimulus step and popped after it.
module tb_traffic_light_fsm;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Slow_Clock = 1'b0;
  logic        Ped_Req = 1'b0;
  logic [2:0]  NS_Light;
  logic [2:0]  EW_Light;
  logic        Walk;
  logic [3:0]  Time_Left;
  logic [10:0] obs;
  logic [10:0] e;
  logic [10:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  traffic_light_fsm dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Slow_Clock (Slow_Clock),
    .Ped_Req    (Ped_Req),
    .NS_Light   (NS_Light),
    .EW_Light   (EW_Light),
    .Walk       (Walk),
    .Time_Left  (Time_Left)
  );

  always #5 Clk = ~Clk;

  assign obs = {NS_Light, EW_Light, Walk, Time_Left};

  function automatic logic [10:0] mk(input logic [2:0] ns,
                                     input logic [2:0] ew,
                                     input logic w,
                                     input int tl);
    return {ns, ew, w, 4'(tl)};
  endfunction

  task automatic do_tick();
    @(negedge Clk) Slow_Clock = 1'b1;
    @(negedge Clk) Slow_Clock = 1'b0;
  endtask

  task automatic press(input int n);
    @(negedge Clk) Ped_Req = 1'b1;
    repeat (n) @(negedge Clk);
    Ped_Req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    sb.push_back(mk(R, R, 1'b0, 1));
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_hold got %b want %b", obs, e);
    end
    Reset = 1'b1;
    sb.push_back(mk(G, R, 1'b0, 8));
    do_tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL first_green got %b want %b", obs, e);
    end
  endtask

  task automatic test_no_ped();
    logic [2:0] ns_t[6];
    logic [2:0] ew_t[6];
    int dur[6];
    int pi;
    int t;
    ns_t = '{G, Y, R, R, R, R};
    ew_t = '{R, R, R, G, Y, R};
    dur  = '{8, 3, 1, 8, 3, 1};
    pi = 0;
    t  = 8;
    for (int k = 0; k < 24; k++) begin
      if (t == 1) begin
        pi = (pi + 1) % 6;
        t  = dur[pi];
      end else begin
        t--;
      end
      sb.push_back(mk(ns_t[pi], ew_t[pi], 1'b0, t));
      do_tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL cycle_%0d got %b want %b", k, obs, e);
      end
    end
  endtask

  task automatic test_truncation();
    sb.push_back(mk(G, R, 1'b0, 7));
    sb.push_back(mk(G, R, 1'b0, 6));
    repeat (2) begin
      do_tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL trunc_lead got %b want %b", obs, e);
      end
    end
    @(negedge Clk) Ped_Req = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (Time_Left !== 4'd6) begin
      errors++;
      $display("FAIL trunc_early got %0d want 6", Time_Left);
    end
    @(negedge Clk);
    Ped_Req = 1'b0;
    checks++;
    if (obs !== mk(G, R, 1'b0, 2)) begin
      errors++;
      $display("FAIL trunc_edge4 got %b want %b", obs, mk(G, R, 1'b0, 2));
    end
    sb.push_back(mk(G, R, 1'b0, 1));
    for (int t = 3; t >= 1; t--) sb.push_back(mk(R == R ? Y : Y, R, 1'b0, t));
    sb.push_back(mk(R, R, 1'b0, 1));
    for (int t = 5; t >= 1; t--) sb.push_back(mk(R, R, 1'b1, t));
    sb.push_back(mk(R, G, 1'b0, 8));
    while (sb.size() > 0) begin
      do_tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL trunc_walk got %b want %b", obs, e);
      end
    end
  endtask

  task automatic test_no_trunc();
    for (int t = 7; t >= 2; t--) sb.push_back(mk(R, G, 1'b0, t));
    while (sb.size() > 0) begin
      do_tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ew_lead got %b want %b", obs, e);
      end
    end
    press(3);
    repeat (6) @(negedge Clk);
    checks++;
    if (obs !== mk(R, G, 1'b0, 2)) begin
      errors++;
      $display("FAIL no_trunc got %b want %b", obs, mk(R, G, 1'b0, 2));
    end
    sb.push_back(mk(R, G, 1'b0, 1));
    for (int t = 3; t >= 1; t--) sb.push_back(mk(R, Y, 1'b0, t));
    sb.push_back(mk(R, R, 1'b0, 1));
    for (int t = 5; t >= 1; t--) sb.push_back(mk(R, R, 1'b1, t));
    sb.push_back(mk(G, R, 1'b0, 8));
    while (sb.size() > 0) begin
      do_tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ew_walk got %b want %b", obs, e);
      end
    end
  endtask

  task automatic test_walk_ignore();
    press(4);
    checks++;
    if (obs !== mk(G, R, 1'b0, 2)) begin
      errors++;
      $display("FAIL wi_trunc got %b want %b", obs, mk(G, R, 1'b0, 2));
    end
    sb.push_back(mk(G, R, 1'b0, 1));
    for (int t = 3; t >= 1; t--) sb.push_back(mk(Y, R, 1'b0, t));
    sb.push_back(mk(R, R, 1'b0, 1));
    sb.push_back(mk(R, R, 1'b1, 5));
    while (sb.size() > 0) begin
      do_tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL wi_enter got %b want %b", obs, e);
      end
    end
    repeat (3) begin
      press(3);
      repeat (3) @(negedge Clk);
    end
    checks++;
    if (obs !== mk(R, R, 1'b1, 5)) begin
      errors++;
      $display("FAIL wi_press got %b want %b", obs, mk(R, R, 1'b1, 5));
    end
    @(negedge Clk) Slow_Clock = 1'b1;
    repeat (10) @(negedge Clk);
    Slow_Clock = 1'b0;
    checks++;
    if (obs !== mk(R, R, 1'b1, 4)) begin
      errors++;
      $display("FAIL held_high got %b want %b", obs, mk(R, R, 1'b1, 4));
    end
    for (int t = 3; t >= 1; t--) sb.push_back(mk(R, R, 1'b1, t));
    for (int t = 8; t >= 1; t--) sb.push_back(mk(R, G, 1'b0, t));
    for (int t = 3; t >= 1; t--) sb.push_back(mk(R, Y, 1'b0, t));
    sb.push_back(mk(R, R, 1'b0, 1));
    sb.push_back(mk(G, R, 1'b0, 8));
    while (sb.size() > 0) begin
      do_tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL wi_after got %b want %b", obs, e);
      end
    end
  endtask

  task automatic test_reset_walk();
    press(4);
    sb.push_back(mk(G, R, 1'b0, 1));
    for (int t = 3; t >= 1; t--) sb.push_back(mk(Y, R, 1'b0, t));
    sb.push_back(mk(R, R, 1'b0, 1));
    sb.push_back(mk(R, R, 1'b1, 5));
    sb.push_back(mk(R, R, 1'b1, 4));
    while (sb.size() > 0) begin
      do_tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rw_enter got %b want %b", obs, e);
      end
    end
    press(4);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (obs !== mk(R, R, 1'b0, 1)) begin
      errors++;
      $display("FAIL async_rst got %b want %b", obs, mk(R, R, 1'b0, 1));
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (obs !== mk(R, R, 1'b0, 1)) begin
      errors++;
      $display("FAIL rst_hold got %b want %b", obs, mk(R, R, 1'b0, 1));
    end
    Reset = 1'b1;
    sb.push_back(mk(G, R, 1'b0, 8));
    sb.push_back(mk(G, R, 1'b0, 7));
    while (sb.size() > 0) begin
      do_tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rw_after got %b want %b", obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_ped();
    test_truncation();
    test_no_trunc();
    test_walk_ignore();
    test_reset_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
